// File: rtl/pipe_result_sink_sv.sv
// Result sink for the pipelined adder: FWFT FIFO with early stall, overflow flag and beat counter.
// Stall is decoded from registered occupancy only, so SKID slots absorb beats still in flight.
module pipe_result_sink_sv #(
   parameter int DW    = 32,
   parameter int DEPTH = 8,
   parameter int SKID  = 2
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush,
   input  logic                     in_vld,
   input  logic [DW-1:0]            in_data,
   output logic                     stall,
   output logic                     out_vld,
   output logic [DW-1:0]            out_data,
   input  logic                     out_rdy,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf,
   output logic [15:0]              total
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          rd;
   logic          wr;
   logic          drop;

   assign out_vld  = (count != '0);
   assign out_data = mem[rd_ptr];
   assign rd       = out_vld & out_rdy;
   // a read in the same cycle frees the slot, so a full FIFO still accepts
   assign wr       = in_vld & ((count < CW'(DEPTH)) | rd);
   assign drop     = in_vld & ~wr;
   assign stall    = (count >= CW'(DEPTH - SKID));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         total  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (wr) begin
            wr_ptr <= wr_ptr + 1'b1;
            total  <= total + 16'd1;
         end
         if (rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (drop) begin
            ovf <= 1'b1;
         end
         count <= count + CW'(wr) - CW'(rd);
      end
   end

   // storage carries no reset; contents behind rd_ptr are never presented
   always_ff @(posedge clk) begin
      if (wr && !flush) begin
         mem[wr_ptr] <= in_data;
      end
   end

endmodule
